// File: rtl/rom_load_sequencer.sv
// ROM image load sequencer: decodes the HPS ioctl download stream into per-target
// write requests with handshaked acknowledge, captures DIP switch bytes, reports load status.
module rom_load_sequencer #(
    parameter logic [24:0] EXPECTED_BYTES = 25'h19000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [2:0]  tgt_req,
    output logic [15:0] tgt_addr,
    output logic [7:0]  tgt_data,
    input  logic [2:0]  tgt_ack,
    output logic [63:0] dip_sw,
    output logic        rom_ready,
    output logic        load_error,
    output logic [24:0] byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    logic [1:0]  rst_sync_q;
    logic        rst_n_int;

    state_t      state_q, state_d;
    logic        download_q;
    logic [2:0]  tgt_req_q, tgt_req_d;
    logic [15:0] tgt_addr_q, tgt_addr_d;
    logic [7:0]  tgt_data_q, tgt_data_d;
    logic        ioctl_wait_q, ioctl_wait_d;
    logic        rom_ready_q, rom_ready_d;
    logic        load_error_q, load_error_d;
    logic [24:0] byte_count_q, byte_count_d;
    logic [63:0] dip_sw_q, dip_sw_d;

    logic        dl_rise;
    logic        rom_wr;
    logic        dip_wr;
    logic [2:0]  dec_sel;
    logic [15:0] dec_addr;

    // Assertion passes straight through; release is delayed two clk_sys edges.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    always_comb begin
        dec_sel  = 3'b000;
        dec_addr = 16'h0000;
        if (ioctl_addr < 25'h10000) begin
            dec_sel  = 3'b001;
            dec_addr = ioctl_addr[15:0];
        end else if (ioctl_addr < 25'h18000) begin
            dec_sel  = 3'b010;
            dec_addr = {1'b0, ioctl_addr[14:0]};
        end else if (ioctl_addr < 25'h19000) begin
            dec_sel  = 3'b100;
            dec_addr = {4'b0000, ioctl_addr[11:0]};
        end
    end

    assign dl_rise = ioctl_download && !download_q && (ioctl_index == 8'd0);
    assign rom_wr  = ioctl_wr && (ioctl_index == 8'd0);
    assign dip_wr  = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);

    always_comb begin
        state_d      = state_q;
        tgt_req_d    = tgt_req_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_data_d   = tgt_data_q;
        ioctl_wait_d = ioctl_wait_q;
        rom_ready_d  = rom_ready_q;
        load_error_d = load_error_q;
        byte_count_d = byte_count_q;
        dip_sw_d     = dip_sw_q;

        case (state_q)
            IDLE, DONE, ERROR: begin
                if (dl_rise) begin
                    state_d      = LOAD;
                    byte_count_d = 25'd0;
                    rom_ready_d  = 1'b0;
                    load_error_d = 1'b0;
                end
            end
            LOAD: begin
                // Download level is checked here so a drop seen during WRITE is honoured on return.
                if (!ioctl_download) begin
                    if ((byte_count_q == EXPECTED_BYTES) && !load_error_q) begin
                        state_d     = DONE;
                        rom_ready_d = 1'b1;
                    end else begin
                        state_d      = ERROR;
                        rom_ready_d  = 1'b0;
                        load_error_d = 1'b1;
                    end
                end else if (rom_wr) begin
                    if (dec_sel != 3'b000) begin
                        state_d      = WRITE;
                        tgt_req_d    = dec_sel;
                        tgt_addr_d   = dec_addr;
                        tgt_data_d   = ioctl_dout;
                        ioctl_wait_d = 1'b1;
                    end else begin
                        load_error_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if ((tgt_ack & tgt_req_q) != 3'b000) begin
                    state_d      = LOAD;
                    tgt_req_d    = 3'b000;
                    ioctl_wait_d = 1'b0;
                    if (byte_count_q != 25'h1FFFFFF) begin
                        byte_count_d = byte_count_q + 25'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (dip_wr) begin
            dip_sw_d[{ioctl_addr[2:0], 3'b000} +: 8] = ioctl_dout;
        end
    end

    // download_q resets high so a download already active at reset release is not taken as a new edge.
    always_ff @(posedge clk_sys or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q      <= IDLE;
            download_q   <= 1'b1;
            tgt_req_q    <= 3'b000;
            tgt_addr_q   <= 16'h0000;
            tgt_data_q   <= 8'h00;
            ioctl_wait_q <= 1'b0;
            rom_ready_q  <= 1'b0;
            load_error_q <= 1'b0;
            byte_count_q <= 25'd0;
            dip_sw_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            download_q   <= ioctl_download;
            tgt_req_q    <= tgt_req_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_data_q   <= tgt_data_d;
            ioctl_wait_q <= ioctl_wait_d;
            rom_ready_q  <= rom_ready_d;
            load_error_q <= load_error_d;
            byte_count_q <= byte_count_d;
            dip_sw_q     <= dip_sw_d;
        end
    end

    assign ioctl_wait = ioctl_wait_q;
    assign tgt_req    = tgt_req_q;
    assign tgt_addr   = tgt_addr_q;
    assign tgt_data   = tgt_data_q;
    assign dip_sw     = dip_sw_q;
    assign rom_ready  = rom_ready_q;
    assign load_error = load_error_q;
    assign byte_count = byte_count_q;

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Randomized testbench for rom_load_sequencer against a behavioural address-map and load-status model.
module tb_rom_load_sequencer;

    // Image size scaled down so a complete load fits a short run.
    localparam logic [24:0] IMG = 25'd48;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [2:0]  tgt_req;
    logic [15:0] tgt_addr;
    logic [7:0]  tgt_data;
    logic [2:0]  tgt_ack;
    logic [63:0] dip_sw;
    logic        rom_ready;
    logic        load_error;
    logic [24:0] byte_count;

    rom_load_sequencer #(.EXPECTED_BYTES(IMG)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .tgt_req        (tgt_req),
        .tgt_addr       (tgt_addr),
        .tgt_data       (tgt_data),
        .tgt_ack        (tgt_ack),
        .dip_sw         (dip_sw),
        .rom_ready      (rom_ready),
        .load_error     (load_error),
        .byte_count     (byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_count = 0;
    bit          exp_error = 1'b0;
    logic [63:0] exp_dip = 64'd0;
    int          model_hits [3] = '{0, 0, 0};
    int          hit_cnt [3] = '{0, 0, 0};
    int          onehot_viol = 0;
    logic [2:0]  req_prev = 3'b000;

    // Observed request pulses per target and one-hot violations, sampled mid-cycle.
    always @(negedge clk_sys) begin
        if ($countones(tgt_req) > 1) onehot_viol++;
        for (int t = 0; t < 3; t++) begin
            if (tgt_req[t] && !req_prev[t]) hit_cnt[t]++;
        end
        req_prev = tgt_req;
    end

    function automatic int ref_target(input int a);
        if (a < 65536)  return 0;
        if (a < 98304)  return 1;
        if (a < 102400) return 2;
        return -1;
    endfunction

    function automatic int ref_local(input int a);
        case (ref_target(a))
            0:       return a;
            1:       return a - 65536;
            2:       return a - 98304;
            default: return 0;
        endcase
    endfunction

    function automatic int rand_in_region(input int r);
        case (r)
            0:       return int'($urandom_range(0, 65535));
            1:       return 65536 + int'($urandom_range(0, 32767));
            default: return 98304 + int'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic write_byte(input int a, input logic [7:0] d, input int ack_delay,
                              input bit noise, input bit drop_dl);
        int         t;
        logic [2:0] exp_req;
        logic [15:0] exp_addr;
        t = ref_target(a);
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        if (t < 0) begin
            exp_error = 1'b1;
            vectors++;
            if ({tgt_req, ioctl_wait, load_error} !== {3'b000, 1'b0, 1'b1} || byte_count !== 25'(exp_count)) begin
                miscompares++;
                $display("[TB] FAIL oor_write addr=%h: req=%b wait=%b err=%b cnt=%0d, want req=000 wait=0 err=1 cnt=%0d",
                         a, tgt_req, ioctl_wait, load_error, byte_count, exp_count);
            end
            return;
        end
        exp_req  = 3'b001 << t;
        exp_addr = 16'(ref_local(a));
        vectors++;
        if ({tgt_req, tgt_addr, tgt_data, ioctl_wait} !== {exp_req, exp_addr, d, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL req_issue addr=%h: req=%b taddr=%h data=%h wait=%b, want %b %h %h 1",
                     a, tgt_req, tgt_addr, tgt_data, ioctl_wait, exp_req, exp_addr, d);
        end
        if (drop_dl) ioctl_download = 1'b0;
        for (int i = 1; i < ack_delay; i++) begin
            if (noise) begin
                ioctl_wr   = 1'b1;
                ioctl_addr = 25'($urandom_range(0, 25'h18FFF));
                ioctl_dout = 8'($urandom);
                tgt_ack    = ~exp_req & (3'($urandom_range(0, 7)) | 3'b001);
            end
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            tgt_ack  = 3'b000;
            vectors++;
            if ({tgt_req, tgt_addr, tgt_data, ioctl_wait} !== {exp_req, exp_addr, d, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL req_hold addr=%h cyc=%0d: req=%b taddr=%h data=%h wait=%b, want %b %h %h 1",
                         a, i, tgt_req, tgt_addr, tgt_data, ioctl_wait, exp_req, exp_addr, d);
            end
        end
        tgt_ack = exp_req;
        @(negedge clk_sys);
        tgt_ack = 3'b000;
        exp_count++;
        model_hits[t]++;
        vectors++;
        if ({tgt_req, ioctl_wait} !== 4'b0000 || byte_count !== 25'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL req_release addr=%h: req=%b wait=%b cnt=%0d, want 000 0 %0d",
                     a, tgt_req, ioctl_wait, byte_count, exp_count);
        end
    endtask

    task automatic start_download();
        @(negedge clk_sys);
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        exp_count = 0;
        exp_error = 1'b0;
        vectors++;
        if ({byte_count, rom_ready, load_error} !== {25'd0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL start_clear: cnt=%0d ready=%b err=%b, want 0 0 0", byte_count, rom_ready, load_error);
        end
    endtask

    task automatic end_download(input string name);
        bit ok;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        ok = (exp_count == int'(IMG)) && !exp_error;
        vectors++;
        if ({rom_ready, load_error} !== {ok, !ok} || byte_count !== 25'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL %s_end: ready=%b err=%b cnt=%0d, want %b %b %0d",
                     name, rom_ready, load_error, byte_count, ok, !ok, exp_count);
        end
    endtask

    task automatic dip_write(input logic [7:0] idx, input int a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_index = idx;
        ioctl_wr    = 1'b1;
        ioctl_addr  = 25'(a);
        ioctl_dout  = d;
        @(negedge clk_sys);
        ioctl_wr    = 1'b0;
        ioctl_index = 8'd0;
        if (idx == 8'd254 && a < 8) exp_dip[a*8 +: 8] = d;
        vectors++;
        if (dip_sw !== exp_dip || {tgt_req, ioctl_wait} !== 4'b0000 || byte_count !== 25'(exp_count)) begin
            miscompares++;
            $display("[TB] FAIL dip_write idx=%0d addr=%0d: dip=%h req=%b wait=%b cnt=%0d, want %h 000 0 %0d",
                     idx, a, dip_sw, tgt_req, ioctl_wait, byte_count, exp_dip, exp_count);
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        tgt_ack        = 3'b000;
        repeat (2) @(negedge clk_sys);
        vectors++;
        if ({tgt_req, tgt_addr, tgt_data, ioctl_wait} !== 28'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_tgt: req=%b addr=%h data=%h wait=%b, want all 0", tgt_req, tgt_addr, tgt_data, ioctl_wait);
        end
        vectors++;
        if ({rom_ready, load_error, byte_count} !== 27'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_status: ready=%b err=%b cnt=%0d, want 0 0 0", rom_ready, load_error, byte_count);
        end
        vectors++;
        if (dip_sw !== 64'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_dip: dip=%h, want 0", dip_sw);
        end
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
    endtask

    task automatic test_full_image();
        int base [3];
        int addrs [$];
        int bnd [6] = '{0, 65535, 65536, 98303, 98304, 102399};
        for (int t = 0; t < 3; t++) begin
            base[t] = hit_cnt[t];
            model_hits[t] = 0;
        end
        foreach (bnd[i]) addrs.push_back(bnd[i]);
        while (addrs.size() < int'(IMG)) addrs.push_back(rand_in_region(addrs.size() % 3));
        start_download();
        foreach (addrs[i]) begin
            write_byte(addrs[i], 8'($urandom), int'($urandom_range(1, 4)),
                       $urandom_range(0, 2) == 0, i == addrs.size() - 1);
        end
        end_download("full_image");
        for (int t = 0; t < 3; t++) begin
            vectors++;
            if (hit_cnt[t] - base[t] != model_hits[t]) begin
                miscompares++;
                $display("[TB] FAIL full_hits tgt%0d: got %0d, want %0d", t, hit_cnt[t] - base[t], model_hits[t]);
            end
        end
    endtask

    task automatic test_stall();
        start_download();
        write_byte(32'h10005, 8'($urandom), 20, 1'b1, 1'b0);
        end_download("stall");
    endtask

    task automatic test_out_of_range();
        start_download();
        write_byte(rand_in_region(0), 8'($urandom), 2, 1'b0, 1'b0);
        write_byte(32'h19000, 8'h5A, 1, 1'b0, 1'b0);
        write_byte(int'($urandom_range(25'h19000, 25'h1FFFFFF)), 8'($urandom), 1, 1'b0, 1'b0);
        write_byte(rand_in_region(2), 8'($urandom), 1, 1'b0, 1'b0);
        end_download("out_of_range");
    endtask

    task automatic test_short_image();
        start_download();
        for (int i = 0; i < int'(IMG) - 1; i++) begin
            write_byte(rand_in_region(int'($urandom_range(0, 2))), 8'($urandom), 1, 1'b0, 1'b0);
        end
        end_download("short_image");
    endtask

    task automatic test_dip();
        start_download();
        for (int i = 0; i < 3; i++) write_byte(rand_in_region(i), 8'($urandom), 2, 1'b0, 1'b0);
        dip_write(8'd254, 3, 8'hA5);
        vectors++;
        if (dip_sw[31:24] !== 8'hA5) begin
            miscompares++;
            $display("[TB] FAIL dip_byte3: got %h, want a5", dip_sw[31:24]);
        end
        dip_write(8'd254, 8, 8'h11);
        dip_write(8'd5, int'($urandom_range(0, 65535)), 8'($urandom));
        for (int i = 0; i < 4; i++) dip_write(8'd254, int'($urandom_range(0, 9)), 8'($urandom));
        for (int i = 3; i < int'(IMG); i++) begin
            write_byte(rand_in_region(int'($urandom_range(0, 2))), 8'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0);
        end
        end_download("dip_load");
        dip_write(8'd254, int'($urandom_range(0, 7)), 8'($urandom));
    endtask

    task automatic test_reset_mid_write();
        logic [7:0] d;
        d = 8'($urandom);
        start_download();
        @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h00100;
        ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        vectors++;
        if ({tgt_req, tgt_addr, ioctl_wait} !== {3'b001, 16'h0100, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_req: req=%b addr=%h wait=%b, want 001 0100 1", tgt_req, tgt_addr, ioctl_wait);
        end
        #2 reset_n = 1'b0;
        #1;
        exp_count = 0;
        exp_error = 1'b0;
        exp_dip   = 64'd0;
        vectors++;
        if ({tgt_req, tgt_addr, tgt_data, ioctl_wait, rom_ready, load_error, byte_count, dip_sw} !== 120'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_immediate: req=%b addr=%h data=%h wait=%b ready=%b err=%b cnt=%0d dip=%h, want all 0",
                     tgt_req, tgt_addr, tgt_data, ioctl_wait, rom_ready, load_error, byte_count, dip_sw);
        end
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (4) @(negedge clk_sys);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h00200;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
        vectors++;
        if ({tgt_req, ioctl_wait, byte_count} !== 29'd0) begin
            miscompares++;
            $display("[TB] FAIL rst_stay_idle: req=%b wait=%b cnt=%0d, want 000 0 0", tgt_req, ioctl_wait, byte_count);
        end
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        start_download();
        write_byte(32'h00100, d, 2, 1'b0, 1'b0);
        end_download("rst_reload");
    endtask

    initial begin
        $display("[TB] rom_load_sequencer bench start");
        test_reset();
        test_full_image();
        test_stall();
        test_out_of_range();
        test_short_image();
        test_dip();
        test_reset_mid_write();
        vectors++;
        if (onehot_viol != 0) begin
            miscompares++;
            $display("[TB] FAIL onehot_req: %0d cycles with multiple req bits, want 0", onehot_viol);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_load_sequencer.md
ROM_LOAD_SEQUENCER -- requirements
Module: rom_load_sequencer

Interface
REQ-001 The block SHALL have the parameter EXPECTED_BYTES, default 25'h19000, the byte count of a complete ROM image.
REQ-002 The block SHALL have the port clk_sys, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have the port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have the ports ioctl_download (in, 1), ioctl_index (in, 8), ioctl_wr (in, 1), ioctl_addr (in, 25) and ioctl_dout (in, 8): the HPS download stream.
REQ-005 The block SHALL have the port ioctl_wait, output, 1 bit: holds off the HPS while a byte is pending.
REQ-006 The block SHALL have the ports tgt_req (out, 3), tgt_addr (out, 16) and tgt_data (out, 8): the write request to target memories; bit 0 = CPU ROM, bit 1 = video ROM, bit 2 = sound ROM.
REQ-007 The block SHALL have the port tgt_ack, input, 3 bits: per-target write acknowledge, a one-cycle pulse.
REQ-008 The block SHALL have the port dip_sw, output, 64 bits: eight captured DIP bytes, byte n at bits [8n+7:8n].
REQ-009 The block SHALL have the ports rom_ready (out, 1), load_error (out, 1) and byte_count (out, 25): load status.

Function
REQ-010 Address decode (index 0 only):
- 0x00000-0x0FFFF: CPU ROM, tgt_addr = addr[15:0].
- 0x10000-0x17FFF: video ROM, tgt_addr = {1'b0, addr[14:0]}.
- 0x18000-0x18FFF: sound ROM, tgt_addr = {4'b0, addr[11:0]}.
- addr >= 0x19000: out of range.
REQ-011 The state machine SHALL have the states IDLE, LOAD, WRITE, DONE and ERROR.
REQ-012 IDLE -> LOAD on a rising edge of ioctl_download with ioctl_index==0: clears byte_count, rom_ready and load_error in that cycle.
REQ-013 In LOAD, an ioctl_wr with an in-range address SHALL do all of the following on the next edge: latch address and data, drive the matching single tgt_req bit high, assert ioctl_wait, and go to WRITE.
REQ-014 In WRITE, tgt_req, tgt_addr, tgt_data and ioctl_wait SHALL hold stable until the tgt_ack bit matching the active target is 1.
REQ-015 When that ack arrives, the next edge SHALL do all of the following: drop tgt_req and ioctl_wait, increment byte_count, and return to LOAD. Net throughput is at most one byte per 2 cycles plus ack latency.
REQ-016 In WRITE, tgt_ack bits of non-selected targets SHALL be ignored.
REQ-017 In WRITE, an ioctl_wr arriving while ioctl_wait is high SHALL be ignored.
REQ-018 In LOAD, an ioctl_wr with an out-of-range address SHALL set load_error, issue no tgt_req, and not increment byte_count; the state stays LOAD.
REQ-019 LOAD -> DONE on a falling edge of ioctl_download with no byte pending: rom_ready=1 if byte_count==EXPECTED_BYTES and load_error==0, else load_error=1 and rom_ready=0.
REQ-020 If ioctl_download falls while in WRITE, the pending byte SHALL be completed first; the end-of-load check runs on return to LOAD.
REQ-021 DONE and ERROR are terminal; a new index-0 download rising edge SHALL re-enter LOAD from either.
REQ-022 DONE/ERROR split: DONE when rom_ready=1, ERROR when load_error=1.
REQ-023 DIP capture: for ioctl_wr with ioctl_index==254 and addr[24:3]==0, dip_sw byte addr[2:0] SHALL be written with ioctl_dout on the next edge, in any state, with no ioctl_wait.
REQ-024 DIP writes SHALL NOT affect byte_count or the FSM.
REQ-025 Downloads with any other ioctl_index SHALL be ignored entirely.
REQ-026 byte_count SHALL saturate at 25'h1FFFFFF.
REQ-027 At most one tgt_req bit SHALL be high in any cycle.

Reset
REQ-028 While reset_n=0, the block SHALL asynchronously force all of the following: state IDLE; tgt_req=0, tgt_addr=0, tgt_data=0; ioctl_wait=0; rom_ready=0, load_error=0, byte_count=0; dip_sw=0.
REQ-029 A reset asserted mid-WRITE SHALL drop tgt_req and ioctl_wait immediately; after release the block waits in IDLE for a new download rising edge, even if ioctl_download is already high.
REQ-030 reset_n deassertion SHALL be synchronised to clk_sys before it is used by the FSM.

Verification
REQ-031 Full-image scenario: index 0, 0x19000 sequential writes, ack 1-4 cycles after req -> target hit counts CPU 65536 / video 32768 / sound 4096, byte_count=0x19000, rom_ready=1, load_error=0.
REQ-032 Stall scenario: tgt_ack[1] delayed 20 cycles for addr 0x10005 -> ioctl_wait high exactly until the ack edge, tgt_addr=0x0005 and tgt_data stable throughout, tgt_ack[0] pulses ignored.
REQ-033 Out-of-range scenario: write at addr 0x19000 -> no tgt_req, load_error=1, byte_count unchanged, final rom_ready=0.
REQ-034 Short-image scenario: ioctl_download falls after 0x18FFF bytes -> ERROR, rom_ready=0, load_error=1.
REQ-035 DIP scenario: index 254, writes 0xA5 at addr 3 and 0x11 at addr 8 during an index-0 load -> dip_sw[31:24]=0xA5, addr-8 write dropped, load unaffected.
REQ-036 Reset scenario: reset_n low for 1 cycle mid-WRITE at addr 0x00100 -> tgt_req=0 and ioctl_wait=0 in the same cycle, state IDLE, all outputs 0.
